// File: rtl/uart_rx_sequencer_if.sv
// uart_rx_sequencer_if: serial line in, shift/load/error strobes out.
// The master modport belongs to the sequencer; the slave modport belongs to its environment.
interface uart_rx_sequencer_if;
    logic rx_i;
    logic shift_en_o;
    logic shift_bit_o;
    logic load_data_out_o;
    logic frame_err_o;
    logic busy_o;
    modport master(input rx_i, output shift_en_o, shift_bit_o, load_data_out_o, frame_err_o, busy_o);
    modport slave(output rx_i, input shift_en_o, shift_bit_o, load_data_out_o, frame_err_o, busy_o);
endinterface

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: UART receive FSM with start qualification, mid-bit sampling and stop check.
// Defining UART_RX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_rx_sequencer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input logic clk_i,
    input logic rstb_i,
    uart_rx_sequencer_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    state_t state, state_nxt;
    logic [1:0] sync;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic par, par_nxt;
    logic rxs, last, half;
    assign rxs  = sync[1];
    assign last = cnt == CW'(CLKS_PER_BIT - 1);
    assign half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            sync    <= 2'b11;
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            par     <= 1'b0;
        end else begin
            sync    <= {sync[0], bus.rx_i};
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_cnt <= bit_nxt;
            par     <= par_nxt;
        end
    end
    // par accumulates the XOR of data and parity bits; nonzero means odd parity
    always_comb begin
        state_nxt           = state;
        cnt_nxt             = cnt + 1'b1;
        bit_nxt             = bit_cnt;
        par_nxt             = par;
        bus.shift_en_o      = 1'b0;
        bus.shift_bit_o     = 1'b0;
        bus.load_data_out_o = 1'b0;
        bus.frame_err_o     = 1'b0;
        bus.busy_o          = state != IDLE;
        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                bit_nxt   = '0;
                par_nxt   = 1'b0;
                state_nxt = rxs ? IDLE : START;
            end
            START: if (half) begin
                cnt_nxt   = '0;
                state_nxt = rxs ? IDLE : DATA;
            end
            DATA: if (last) begin
                cnt_nxt         = '0;
                bus.shift_en_o  = 1'b1;
                bus.shift_bit_o = rxs;
                par_nxt         = par ^ rxs;
                bit_nxt         = bit_cnt + 1'b1;
                if (bit_cnt == BW'(DATA_BITS - 1)) begin
                    bit_nxt   = '0;
                    state_nxt = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: if (last) begin
                cnt_nxt   = '0;
                par_nxt   = par ^ rxs;
                state_nxt = STOP;
            end
            STOP: if (last) begin
                cnt_nxt             = '0;
                bus.load_data_out_o = rxs && !(PAR_EN && par);
                bus.frame_err_o     = !rxs || (PAR_EN && par);
                state_nxt           = rxs ? IDLE : BREAK;
            end
            BREAK: begin
                cnt_nxt   = '0;
                state_nxt = rxs ? IDLE : BREAK;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_rx_sequencer.sv
// tb_uart_rx_sequencer: directed frames against uart_rx_sequencer at 16 clocks per bit.
// Honours UART_RX_PARITY_EN so the same bench covers both builds.
module tb_uart_rx_sequencer;
`ifdef UART_RX_PARITY_EN
    localparam int LD_LAT = 170;
`else
    localparam int LD_LAT = 154;
`endif
    logic clk_i = 1'b0;
    logic rstb_i = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_ld = 0, n_er = 0, ld_cyc = 0, viol = 0, prev_s = 0;
    bit sh_b[$];
    int sh_t[$];
    uart_rx_sequencer_if u_if();
    uart_rx_sequencer #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (.clk_i(clk_i), .rstb_i(rstb_i), .bus(u_if));
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) begin
        int s;
        s = int'(u_if.shift_en_o) + int'(u_if.load_data_out_o) + int'(u_if.frame_err_o);
        if (u_if.shift_en_o) begin
            sh_b.push_back(u_if.shift_bit_o);
            sh_t.push_back(cyc);
        end
        if (u_if.load_data_out_o) begin
            n_ld++;
            ld_cyc = cyc;
        end
        if (u_if.frame_err_o) n_er++;
        if (s > 1 || (s != 0 && prev_s != 0)) viol++;
        prev_s = s;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic drive_bit(input logic b);
        u_if.rx_i = b;
        repeat (16) @(negedge clk_i);
    endtask
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbad);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d ^ pbad);
`endif
        drive_bit(stop);
        u_if.rx_i = 1'b1;
    endtask
    function automatic int bits_val(input int from, input int n);
        int v = 0;
        for (int i = 0; i < n; i++) v |= int'(sh_b[from + i]) << i;
        return v;
    endfunction
    initial begin
        int b0, l0, e0, t0, bc;
        u_if.rx_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_shift", u_if.shift_en_o, 0);
        check("rst_load", u_if.load_data_out_o, 0);
        check("rst_err", u_if.frame_err_o, 0);
        check("rst_busy", u_if.busy_o, 0);
        rstb_i = 1'b1;
        repeat (5) @(negedge clk_i);
        // 1: 0xA5 8N1
        b0 = sh_b.size(); l0 = n_ld; e0 = n_er; t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("a5_nshift", sh_b.size() - b0, 8);
        check("a5_data", bits_val(b0, 8), 32'hA5);
        check("a5_first_lat", sh_t[b0] - t0, 26);
        check("a5_bit7_lat", sh_t[b0 + 7] - t0, 26 + 16 * 7);
        check("a5_nload", n_ld - l0, 1);
        check("a5_load_lat", ld_cyc - t0, LD_LAT);
        check("a5_nerr", n_er - e0, 0);
        check("a5_busy", u_if.busy_o, 0);
        // 2: 4-cycle glitch
        b0 = sh_b.size(); l0 = n_ld; e0 = n_er; bc = 0;
        u_if.rx_i = 1'b0;
        repeat (4) @(negedge clk_i);
        u_if.rx_i = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (u_if.busy_o) bc++;
            @(negedge clk_i);
        end
        check("gl_nstrobe", sh_b.size() - b0 + n_ld - l0 + n_er - e0, 0);
        check("gl_busy_seen", bc > 0, 1);
        check("gl_busy_short", bc <= 10, 1);
        check("gl_busy_end", u_if.busy_o, 0);
        // 3: 0x3C with low stop bit and a held-low line
        b0 = sh_b.size(); l0 = n_ld; e0 = n_er;
        send_frame(8'h3C, 1'b0, 1'b0);
        u_if.rx_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check("3c_nshift", sh_b.size() - b0, 8);
        check("3c_data", bits_val(b0, 8), 32'h3C);
        check("3c_nerr", n_er - e0, 1);
        check("3c_nload", n_ld - l0, 0);
        check("3c_busy_break", u_if.busy_o, 1);
        u_if.rx_i = 1'b1;
        repeat (6) @(negedge clk_i);
        check("3c_busy_end", u_if.busy_o, 0);
        check("3c_nshift_after", sh_b.size() - b0, 8);
        // 4: reset in the middle of bit 4 of 0xFF
        drive_bit(1'b0);
        repeat (4) drive_bit(1'b1);
        repeat (8) @(negedge clk_i);
        check("rst_mid_busy_before", u_if.busy_o, 1);
        rstb_i = 1'b0;
        #1;
        check("rst_mid_busy", u_if.busy_o, 0);
        check("rst_mid_shift", u_if.shift_en_o, 0);
        check("rst_mid_load", u_if.load_data_out_o, 0);
        b0 = sh_b.size(); l0 = n_ld; e0 = n_er;
        @(negedge clk_i);
        repeat (20) @(negedge clk_i);
        rstb_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_mid_nstrobe", sh_b.size() - b0 + n_ld - l0 + n_er - e0, 0);
        send_frame(8'h12, 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("12_nshift", sh_b.size() - b0, 8);
        check("12_data", bits_val(b0, 8), 32'h12);
        check("12_nload", n_ld - l0, 1);
        // 5: 0x00 then 0xFF back-to-back
        b0 = sh_b.size(); l0 = n_ld; e0 = n_er;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("b2b_nshift", sh_b.size() - b0, 16);
        check("b2b_data", bits_val(b0, 16), 32'hFF00);
        check("b2b_nload", n_ld - l0, 2);
        check("b2b_nerr", n_er - e0, 0);
`ifdef UART_RX_PARITY_EN
        // 6: parity good then bad on 0x07
        l0 = n_ld; e0 = n_er;
        send_frame(8'h07, 1'b1, 1'b0);
        repeat (4) @(negedge clk_i);
        check("par_ok_load", n_ld - l0, 1);
        check("par_ok_err", n_er - e0, 0);
        l0 = n_ld; e0 = n_er;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk_i);
        check("par_bad_load", n_ld - l0, 0);
        check("par_bad_err", n_er - e0, 1);
        check("par_bad_busy", u_if.busy_o, 0);
`endif
        check("strobe_exclusive", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
